grant_burst_engine: RTL and testbench

- Downstream consumer of the two-requester grant FSM. Takes its registered gnt_0/gnt_1 and moves a burst of LEN beats from the granted requester onto one shared valid/ready output channel.
- Pulses a per-requester done when the burst finishes, so the requester can drop its req. It then waits for the grant to release before accepting a new one.
- Sits between the arbiter and the shared sink.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/grant_burst_engine_if.sv | 13 +
 rtl/grant_burst_engine.sv | 106 ++++++++++
 tb/tb_grant_burst_engine.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester arbiter and the grant burst engine.
package arb_pkg;

    // Burst engine state register, one-hot.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_XFER = 4'b0010,
        ST_DONE = 4'b0100,
        ST_WREL = 4'b1000
    } eng_state_t;

    // Requester / source identifiers.
    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    // Arbiter states. They are kept here so both blocks use the same definition.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/grant_burst_engine_if.sv
// Shared valid/ready burst channel from the engine to the downstream sink.
interface grant_burst_engine_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              src;
    logic              last;

    modport master (output valid, output data, output src, output last, input ready);
    modport slave  (input valid, input data, input src, input last, output ready);
endinterface

// File: rtl/grant_burst_engine.sv
// Moves a LEN-beat burst from the granted requester onto the shared output
// channel, pulses done for that requester, then waits for the grant to drop.
module grant_burst_engine
    import arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  gnt_0,
    input  logic                  gnt_1,
    input  logic [LEN_W-1:0]      len_0,
    input  logic [LEN_W-1:0]      len_1,
    input  logic [DATA_W-1:0]     data_0,
    input  logic [DATA_W-1:0]     data_1,
    output logic                  rd_0,
    output logic                  rd_1,
    grant_burst_engine_if.master  out,
    output logic                  done_0,
    output logic                  done_1,
    output logic                  busy,
    output logic                  err
);

    eng_state_t       state;
    logic             sel;
    logic [LEN_W-1:0] rem;
    logic             err_q;

    logic              xfer;
    logic              accept;
    logic              gnt_sel;
    logic [DATA_W-1:0] data_sel;

    assign xfer     = (state == ST_XFER);
    assign gnt_sel  = (sel == SRC1) ? gnt_1 : gnt_0;
    assign data_sel = (sel == SRC1) ? data_1 : data_0;
    assign accept   = xfer && out.ready;

    // NOTE: payload is forced to zero outside XFER so an idle channel never
    // shows a requester's stale data.
    assign out.valid = xfer;
    assign out.data  = xfer ? data_sel : '0;
    assign out.src   = sel;
    assign out.last  = xfer && (rem == LEN_W'(1));

    assign rd_0   = accept && (sel == SRC0);
    assign rd_1   = accept && (sel == SRC1);
    assign done_0 = (state == ST_DONE) && (sel == SRC0);
    assign done_1 = (state == ST_DONE) && (sel == SRC1);
    assign busy   = (state != ST_IDLE);
    assign err    = err_q;

    // Burst sequencing: grant acceptance, beat counting, abort and release.
    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous; it is only seen on a rising clock edge,
        // so it lives inside the clocked branch, not the sensitivity list.
        if (reset) begin
            state <= ST_IDLE;
            sel   <= SRC0;
            rem   <= '0;
            err_q <= 1'b0;
        end else begin
            // NOTE: err defaults low every cycle so any set below is a single pulse.
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_0 && gnt_1) begin
                        err_q <= 1'b1;
                    end else if (gnt_0) begin
                        sel <= SRC0;
                        rem <= len_0;
                        if (len_0 != '0) state <= ST_XFER;
                        else             state <= ST_DONE;
                    end else if (gnt_1) begin
                        sel <= SRC1;
                        rem <= len_1;
                        if (len_1 != '0) state <= ST_XFER;
                        else             state <= ST_DONE;
                    end
                end
                ST_XFER: begin
                    // A beat accepted in the abort cycle still counts.
                    if (accept && (rem != '0)) rem <= rem - LEN_W'(1);
                    if (!gnt_sel) begin
                        state <= ST_IDLE;
                        err_q <= 1'b1;
                    end else if (accept && (rem == LEN_W'(1))) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_WREL;
                end
                ST_WREL: begin
                    if (!gnt_sel) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_burst_engine.sv
// Self-checking bench for grant_burst_engine: directed scenarios, randomized
// bursts and a short run behind a behavioural two-requester arbiter.
module tb_grant_burst_engine;
    import arb_pkg::*;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              src;
        logic              last;
    } beat_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              gnt_0, gnt_1;
    logic              tb_gnt_0, tb_gnt_1;
    logic [LEN_W-1:0]  len_0, len_1;
    logic [DATA_W-1:0] data_0, data_1;
    logic              rd_0, rd_1, done_0, done_1, busy, err;

    // arbiter model
    logic       arb_mode;
    logic       req_0, req_1;
    logic       arb_g0, arb_g1;
    arb_state_t arb_st;

    // requester model: data advances by one step per consumed beat
    logic [7:0] seed0, seed1;
    int         idx_0 = 0, idx_1 = 0;
    int         next_idx[2];

    // scoreboard
    beat_t exp_q[$];
    logic  done_q[$];
    int    exp_err = 0, obs_err = 0;
    int    tests = 0, fails = 0;

    grant_burst_engine_if #(.DATA_W(DATA_W)) bus ();

    grant_burst_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clock  (clock),
        .reset  (reset),
        .gnt_0  (gnt_0),
        .gnt_1  (gnt_1),
        .len_0  (len_0),
        .len_1  (len_1),
        .data_0 (data_0),
        .data_1 (data_1),
        .rd_0   (rd_0),
        .rd_1   (rd_1),
        .out    (bus),
        .done_0 (done_0),
        .done_1 (done_1),
        .busy   (busy),
        .err    (err)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] beat_val(input logic [7:0] seed, input int idx);
        return seed + 8'(idx * 29);
    endfunction

    assign data_0 = beat_val(seed0, idx_0);
    assign data_1 = beat_val(seed1, idx_1);
    assign gnt_0  = arb_mode ? arb_g0 : tb_gnt_0;
    assign gnt_1  = arb_mode ? arb_g1 : tb_gnt_1;

    // Requesters step to their next beat after each consumed one.
    always @(posedge clock) begin
        if (rd_0) idx_0 <= idx_0 + 1;
        if (rd_1) idx_1 <= idx_1 + 1;
    end

    // Arbiter model: grant follows req two cycles later, holds while req stays high.
    always @(posedge clock) begin
        if (reset) begin
            arb_st <= ARB_IDLE;
            arb_g0 <= 1'b0;
            arb_g1 <= 1'b0;
        end else begin
            case (arb_st)
                ARB_IDLE: if (req_0) arb_st <= ARB_GNT0; else if (req_1) arb_st <= ARB_GNT1;
                ARB_GNT0: if (!req_0) arb_st <= ARB_IDLE;
                ARB_GNT1: if (!req_1) arb_st <= ARB_IDLE;
                default:  arb_st <= ARB_IDLE;
            endcase
            arb_g0 <= (arb_st == ARB_GNT0);
            arb_g1 <= (arb_st == ARB_GNT1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_beats(input int src, input int count, input int len);
        beat_t b;
        for (int i = 0; i < count; i++) begin
            b.data = beat_val((src == 0) ? seed0 : seed1, next_idx[src] + i);
            b.src  = src[0];
            b.last = (i == len - 1);
            exp_q.push_back(b);
        end
        next_idx[src] += count;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, bus.valid, 0);
        check({tag, "_data"},  bus.data,  0);
        check({tag, "_src"},   bus.src,   0);
        check({tag, "_last"},  bus.last,  0);
        check({tag, "_rd"},    {rd_0, rd_1}, 0);
        check({tag, "_done"},  {done_0, done_1}, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_err"},   err,  0);
    endtask

    // One complete burst from the IDLE cycle the caller is in, back to IDLE.
    task automatic run_burst(input int src, input int len, input int stall,
                             input bit rand_rdy, input int hold);
        int   a = 0;
        bit   fin = 1'b0;
        logic rdy;
        push_beats(src, len, len);
        done_q.push_back(src[0]);
        if (src == 0) begin tb_gnt_0 = 1'b1; len_0 = LEN_W'(len); end
        else          begin tb_gnt_1 = 1'b1; len_1 = LEN_W'(len); end
        bus.ready = 1'($urandom_range(0, 1));
        for (int k = 1; k <= 400 && !fin; k++) begin
            tick();
            if (len != 0 && a < len) begin
                check("xfer_valid", bus.valid, 1);
                check("xfer_last",  bus.last, 32'(len - a == 1));
                check("xfer_src",   bus.src, 32'(src));
                check("xfer_busy",  busy, 1);
                rdy = (k > stall) && (!rand_rdy || ($urandom_range(0, 2) != 0));
                bus.ready = rdy;
                if (rdy) a++;
            end else begin
                check("done_pulse", (src == 0) ? done_0 : done_1, 1);
                check("done_other", (src == 0) ? done_1 : done_0, 0);
                check("done_valid", bus.valid, 0);
                check("done_busy",  busy, 1);
                bus.ready = 1'($urandom_range(0, 1));
                fin = 1'b1;
            end
        end
        check("burst_finished", fin, 1);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("wrel_busy",  busy, 1);
            check("wrel_valid", bus.valid, 0);
            check("wrel_done",  {done_0, done_1}, 0);
            bus.ready = 1'($urandom_range(0, 1));
        end
        tick();
        if (src == 0) tb_gnt_0 = 1'b0; else tb_gnt_1 = 1'b0;
        check("release_busy", busy, 1);
        tick();
        check("idle_busy", busy, 0);
    endtask

    task automatic wait_done(input int src, input string tag);
        bit got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            if ((src == 0) ? done_0 : done_1) got = 1'b1;
        end
        check(tag, got, 1);
    endtask

    // Monitor: compares every presented beat and every done against the scoreboard.
    always @(negedge clock) begin : monitor
        beat_t e;
        logic  d;
        if (!reset) begin
            if (bus.valid) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL beat_unexpected: got data %0h src %0d, expected no beat", bus.data, bus.src);
                end else begin
                    e = exp_q[0];
                    check("beat_data", bus.data, e.data);
                    check("beat_src",  bus.src,  e.src);
                    check("beat_last", bus.last, e.last);
                    if (bus.ready) begin
                        void'(exp_q.pop_front());
                        check("beat_rd", {rd_0, rd_1}, (e.src == SRC0) ? 2'b10 : 2'b01);
                    end
                end
            end
            if (!(bus.valid && bus.ready)) check("rd_idle", {rd_0, rd_1}, 0);
            if (done_0 || done_1) begin
                check("done_onehot", done_0 && done_1, 0);
                if (done_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL done_unexpected: got done_0=%0d done_1=%0d, expected none", done_0, done_1);
                end else begin
                    d = done_q.pop_front();
                    check("done_src", done_1, d);
                end
            end
            if (err) obs_err++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        seed0       = 8'($urandom);
        seed1       = 8'($urandom);
        next_idx[0] = 0;
        next_idx[1] = 0;
        reset       = 1'b1;
        tb_gnt_0    = 1'b0;
        tb_gnt_1    = 1'b0;
        len_0       = '0;
        len_1       = '0;
        bus.ready   = 1'b0;
        arb_mode    = 1'b0;
        req_0       = 1'b0;
        req_1       = 1'b0;

        repeat (3) tick();
        check_quiet("reset");
        reset = 1'b0;
        repeat (7) tick();
        check_quiet("idle");

        // basic, backpressure, zero length, single beat, maximum length
        run_burst(0, 3, 0, 1'b0, 2);
        run_burst(1, 2, 3, 1'b0, 1);
        run_burst(0, 0, 0, 1'b0, 1);
        run_burst(1, 1, 2, 1'b0, 0);
        run_burst(0, 15, 0, 1'b1, 1);

        // illegal double grant, then a legal burst from src 0
        tb_gnt_0 = 1'b1; tb_gnt_1 = 1'b1; len_0 = 4'd5; len_1 = 4'd7;
        tick();
        check("dbl_err",   err, 1);
        check("dbl_busy",  busy, 0);
        check("dbl_valid", bus.valid, 0);
        exp_err++;
        tb_gnt_1 = 1'b0;
        run_burst(0, 2, 0, 1'b0, 1);

        // abort: grant drops while the second of four beats is accepted
        push_beats(0, 2, 4);
        tb_gnt_0 = 1'b1; len_0 = 4'd4; bus.ready = 1'b1;
        tick();
        check("abort_valid1", bus.valid, 1);
        tick();
        check("abort_valid2", bus.valid, 1);
        tb_gnt_0 = 1'b0;
        tick();
        check("abort_err",   err, 1);
        check("abort_busy",  busy, 0);
        check("abort_valid", bus.valid, 0);
        check("abort_done",  done_0, 0);
        exp_err++;
        tick();
        check("abort_err_once", err, 0);

        // reset while beat 2 of 5 is presented
        push_beats(1, 1, 5);
        tb_gnt_1 = 1'b1; len_1 = 4'd5; bus.ready = 1'b1;
        tick();
        check("rstmid_valid1", bus.valid, 1);
        tick();
        check("rstmid_valid2", bus.valid, 1);
        reset = 1'b1; bus.ready = 1'b0; tb_gnt_1 = 1'b0;
        tick();
        check_quiet("rstmid");
        reset = 1'b0;
        tick();
        check("rstmid_idle", busy, 0);
        run_burst(1, 3, 1, 1'b0, 1);

        // randomized bursts
        for (int n = 0; n < 16; n++)
            run_burst(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), 1'b1, int'($urandom_range(0, 3)));

        // behind the arbiter: src 0 len 2, then src 1 len 1
        arb_mode  = 1'b1;
        bus.ready = 1'b1;
        len_0 = 4'd2;
        push_beats(0, 2, 2);
        done_q.push_back(SRC0);
        req_0 = 1'b1;
        wait_done(0, "int_done0");
        req_0 = 1'b0;
        len_1 = 4'd1;
        push_beats(1, 1, 1);
        done_q.push_back(SRC1);
        req_1 = 1'b1;
        wait_done(1, "int_done1");
        req_1 = 1'b0;
        repeat (6) tick();
        check("int_busy", busy, 0);
        arb_mode = 1'b0;

        repeat (4) tick();
        check("beats_drained", exp_q.size(), 0);
        check("dones_drained", done_q.size(), 0);
        check("err_count", obs_err, exp_err);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
